// File: rtl/timer_digit_loader_if.sv
// Keypad-to-loader bundle: key strobes in, digit-counter load buses and status out.
interface timer_digit_loader_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_load;
  logic       key_clear;
  logic       running;
  logic [3:0] sec_u_data;
  logic [3:0] sec_t_data;
  logic [3:0] min_u_data;
  logic [3:0] min_t_data;
  logic       loadn;
  logic [2:0] digit_cnt;
  logic       full;
  logic       err;

  modport master (
    output key_valid, key_code, key_load, key_clear, running,
    input  sec_u_data, sec_t_data, min_u_data, min_t_data,
    input  loadn, digit_cnt, full, err
  );

  modport slave (
    input  key_valid, key_code, key_load, key_clear, running,
    output sec_u_data, sec_t_data, min_u_data, min_t_data,
    output loadn, digit_cnt, full, err
  );
endinterface

// File: rtl/timer_digit_loader.sv
// Collects keypad digits right-to-left into mm:ss and issues a one-cycle
// active-low load strobe to the four digit counters after a range check.
module timer_digit_loader #(
  parameter int MAX_DIGITS   = 4,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic                 clk,
  input  logic                 clr,
  timer_digit_loader_if.slave  bus
);

  localparam logic [2:0] MAX_CNT   = 3'(MAX_DIGITS);
  localparam logic [3:0] SEC_T_LIM = 4'(SEC_TENS_MAX);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, ERR} state_t;

  state_t     state_q, state_d;
  logic [3:0] d0_q, d0_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d2_q, d2_d;
  logic [3:0] d3_q, d3_d;
  logic [2:0] cnt_q, cnt_d;
  logic       loadn_q, loadn_d;
  logic       err_q, err_d;
  logic       full;
  logic       digit_ok;

  assign full     = (cnt_q == MAX_CNT);
  assign digit_ok = bus.key_valid && (bus.key_code <= 4'd9) && !bus.running && !full;

  always_comb begin
    state_d = state_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    cnt_d   = cnt_q;
    loadn_d = loadn_q;
    err_d   = err_q;
    case (state_q)
      LOAD: begin
        // The strobe lasts exactly one cycle; the entry is consumed afterwards.
        state_d = IDLE;
        loadn_d = 1'b1;
        d0_d    = 4'd0;
        d1_d    = 4'd0;
        d2_d    = 4'd0;
        d3_d    = 4'd0;
        cnt_d   = 3'd0;
      end
      ERR: begin
        if (bus.key_clear) begin
          state_d = IDLE;
          err_d   = 1'b0;
          d0_d    = 4'd0;
          d1_d    = 4'd0;
          d2_d    = 4'd0;
          d3_d    = 4'd0;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        if (bus.key_clear) begin
          state_d = IDLE;
          err_d   = 1'b0;
          d0_d    = 4'd0;
          d1_d    = 4'd0;
          d2_d    = 4'd0;
          d3_d    = 4'd0;
          cnt_d   = 3'd0;
        end else if (bus.key_load && !bus.running) begin
          if (cnt_q != 3'd0) begin
            if (d1_q > SEC_T_LIM) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              state_d = LOAD;
              loadn_d = 1'b0;
            end
          end
        end else if (digit_ok) begin
          state_d = ENTRY;
          d3_d    = d2_q;
          d2_d    = d1_q;
          d1_d    = d0_q;
          d0_d    = bus.key_code;
          cnt_d   = cnt_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      d0_q    <= 4'd0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      d3_q    <= 4'd0;
      cnt_q   <= 3'd0;
      loadn_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      cnt_q   <= cnt_d;
      loadn_q <= loadn_d;
      err_q   <= err_d;
    end
  end

  assign bus.sec_u_data = d0_q;
  assign bus.sec_t_data = d1_q;
  assign bus.min_u_data = d2_q;
  assign bus.min_t_data = d3_q;
  assign bus.loadn      = loadn_q;
  assign bus.digit_cnt  = cnt_q;
  assign bus.full       = full;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_timer_digit_loader.sv
// Directed bench for timer_digit_loader: a digit-list model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_timer_digit_loader;

  localparam int MAX_DIGITS = 4;

  logic clk;
  logic clr;
  timer_digit_loader_if bus();

  timer_digit_loader #(.MAX_DIGITS(MAX_DIGITS), .SEC_TENS_MAX(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: the entry is the list of keys typed, interpreted as a decimal number.
  int digs[$];
  bit m_err;
  bit m_loading;
  bit m_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int entry_value();
    int v = 0;
    foreach (digs[i]) v = v * 10 + digs[i];
    return v;
  endfunction

  function automatic int digit_at(int k);
    int v = entry_value();
    for (int i = 0; i < k; i++) v = v / 10;
    return v % 10;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      digs.delete();
      m_err     = 1'b0;
      m_loading = 1'b0;
      m_ready   = 1'b1;
    end else if (m_loading) begin
      m_loading = 1'b0;
      digs.delete();
    end else if (bus.key_clear) begin
      digs.delete();
      m_err = 1'b0;
    end else if (m_err) begin
    end else if (bus.key_load && !bus.running) begin
      if (digs.size() != 0) begin
        if (digit_at(1) > 5) m_err = 1'b1;
        else m_loading = 1'b1;
      end
    end else if (bus.key_valid && !bus.running && bus.key_code <= 4'd9
                 && digs.size() < MAX_DIGITS) begin
      digs.push_back(int'(bus.key_code));
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      checkOutput("sec_u", int'(bus.sec_u_data), digit_at(0));
      checkOutput("sec_t", int'(bus.sec_t_data), digit_at(1));
      checkOutput("min_u", int'(bus.min_u_data), digit_at(2));
      checkOutput("min_t", int'(bus.min_t_data), digit_at(3));
      checkOutput("loadn", int'(bus.loadn), m_loading ? 0 : 1);
      checkOutput("digit_cnt", int'(bus.digit_cnt), digs.size());
      checkOutput("full", int'(bus.full), (digs.size() == MAX_DIGITS) ? 1 : 0);
      checkOutput("err", int'(bus.err), int'(m_err));
    end
  end

  // Presents the strobes for exactly one sampling edge, then drops them.
  task automatic applyStimulus(input bit v, input int code, input bit ld, input bit cl);
    @(posedge clk); #1;
    bus.key_valid = v;
    bus.key_code  = 4'(code);
    bus.key_load  = ld;
    bus.key_clear = cl;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.key_load  = 1'b0;
    bus.key_clear = 1'b0;
  endtask

  task automatic key(input int code);
    applyStimulus(1'b1, code, 1'b0, 1'b0);
  endtask

  task automatic expectTime(input string name, input int mt, input int mu, input int st, input int su,
                            input int ln);
    @(negedge clk);
    checkOutput({name, "_min_t"}, int'(bus.min_t_data), mt);
    checkOutput({name, "_min_u"}, int'(bus.min_u_data), mu);
    checkOutput({name, "_sec_t"}, int'(bus.sec_t_data), st);
    checkOutput({name, "_sec_u"}, int'(bus.sec_u_data), su);
    checkOutput({name, "_loadn"}, int'(bus.loadn), ln);
  endtask

  initial begin
    m_ready       = 1'b0;
    clr           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.key_load  = 1'b0;
    bus.key_clear = 1'b0;
    bus.running   = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    checkOutput("reset_cnt", int'(bus.digit_cnt), 0);
    checkOutput("reset_loadn", int'(bus.loadn), 1);

    // Keys 1,3,0 then load: 01:30 strobed for one cycle.
    key(1); key(3); key(0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    expectTime("t1_load", 0, 1, 3, 0, 0);
    @(posedge clk); #1;
    expectTime("t1_after", 0, 0, 0, 0, 1);
    checkOutput("t1_cnt", int'(bus.digit_cnt), 0);

    // Seconds-tens of 9 is rejected.
    key(9); key(9);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t2_err", int'(bus.err), 1);
    key(4);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t2_err_clr", int'(bus.err), 0);
    checkOutput("t2_cnt", int'(bus.digit_cnt), 0);

    // Fifth digit dropped once full.
    key(1); key(2); key(3); key(4);
    @(negedge clk);
    checkOutput("t3_full", int'(bus.full), 1);
    key(5);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    expectTime("t3_load", 1, 2, 3, 4, 0);

    // Running blocks digits and load, but not clear.
    bus.running = 1'b1;
    key(5); key(5);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t4_cnt", int'(bus.digit_cnt), 0);
    checkOutput("t4_loadn", int'(bus.loadn), 1);
    bus.running = 1'b0;
    key(8);
    bus.running = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t4_clear", int'(bus.digit_cnt), 0);
    bus.running = 1'b0;

    // Load with no digits, then load with a simultaneous digit.
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t5_noload", int'(bus.loadn), 1);
    key(7);
    applyStimulus(1'b1, 3, 1'b1, 1'b0);
    expectTime("t5_load", 0, 0, 0, 7, 0);

    // clr during the load cycle, then an out-of-range code.
    key(2);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    expectTime("t6_clr", 0, 0, 0, 0, 1);
    checkOutput("t6_cnt", int'(bus.digit_cnt), 0);
    key(12);
    @(negedge clk);
    checkOutput("t6_code12", int'(bus.digit_cnt), 0);
    checkOutput("t6_sec_u", int'(bus.sec_u_data), 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
